// File: rtl/fwvexrisc_wb_timer_pkg.sv
// rtl/fwvexrisc_wb_timer_pkg.sv - register map, CTRL layout and byte-lane helper for the Wishbone timer
// Shared by the timer top and its testbench. CTRL write masks depend on whether
// FWVEXRISC_WB_TIMER_PRESCALE_EN is defined (prescale byte implemented or not).
package fwvexrisc_wb_timer_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_COMPARE = 2'd3;

    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_IRQ_EN_BIT      = 1;
    localparam int CTRL_AUTO_RELOAD_BIT = 2;
    localparam int CTRL_PRESCALE_LSB    = 8;

    // Writable CTRL bits; everything else is held at 0 and reads back as 0.
    localparam logic [31:0] CTRL_MASK_BASE = (32'd1 << CTRL_EN_BIT)
                                           | (32'd1 << CTRL_IRQ_EN_BIT)
                                           | (32'd1 << CTRL_AUTO_RELOAD_BIT);
    localparam logic [31:0] CTRL_MASK_FULL = CTRL_MASK_BASE | (32'hFF << CTRL_PRESCALE_LSB);

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  prescale;
        logic [4:0]  rsvd_lo;
        logic        auto_reload;
        logic        irq_en;
        logic        en;
    } ctrl_t;

    // Replace only the bytes whose select bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/fwvexrisc_wb_timer_if.sv
// rtl/fwvexrisc_wb_timer_if.sv - Wishbone classic single-word target bus bundle
// master: drives t_adr/t_dat_w/t_cyc/t_stb/t_we/t_sel, receives t_dat_r/t_ack.
// slave : the timer side of the same signals.
interface fwvexrisc_wb_timer_if;
    logic [31:0] t_adr;
    logic [31:0] t_dat_w;
    logic [31:0] t_dat_r;
    logic        t_cyc;
    logic        t_stb;
    logic        t_we;
    logic [3:0]  t_sel;
    logic        t_ack;

    modport master (output t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
                    input  t_dat_r, t_ack);
    modport slave  (input  t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
                    output t_dat_r, t_ack);
endinterface

// File: rtl/fwvexrisc_timer_prescaler.sv
// rtl/fwvexrisc_timer_prescaler.sv - 8-bit prescaler producing a one-cycle count tick
// Ports: clock, reset (async active-low), en, prescale[7:0] (divide-minus-one),
// clear (restart from 0), tick (high when en and the divider reaches prescale).
module fwvexrisc_timer_prescaler (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] prescale,
    input  logic       clear,
    output logic       tick
);
    logic [7:0] div_q;
    logic [7:0] div_d;

    assign tick = en && (div_q == prescale);

    always_comb begin
        div_d = div_q + 8'd1;
        if (!en || clear || tick) div_d = 8'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) div_q <= 8'd0;
        else        div_q <= div_d;
    end
endmodule

// File: rtl/fwvexrisc_wb_timer.sv
// rtl/fwvexrisc_wb_timer.sv - Wishbone timer: 32-bit counter, compare, auto-reload, sticky pending, irq
// Ports: clock, reset (async active-low), bus (fwvexrisc_wb_timer_if.slave,
// one-cycle registered ack), irq (pending & CTRL.irq_en).
// Build option: FWVEXRISC_WB_TIMER_PRESCALE_EN adds the 8-bit prescaler and CTRL[15:8].
module fwvexrisc_wb_timer
    import fwvexrisc_wb_timer_pkg::*;
#(
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic                      clock,
    input  logic                      reset,
    fwvexrisc_wb_timer_if.slave       bus,
    output logic                      irq
);
`ifdef FWVEXRISC_WB_TIMER_PRESCALE_EN
    localparam logic [31:0] CTRL_MASK = CTRL_MASK_FULL;
`else
    localparam logic [31:0] CTRL_MASK = CTRL_MASK_BASE;
`endif

    ctrl_t       ctrl_q, ctrl_d;
    logic        pending_q, pending_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ack_q;
    logic [31:0] dat_r_q, dat_r_d;

    logic        req, wr, tick, match;
    logic        wr_ctrl, wr_status, wr_count, wr_compare;
    logic [1:0]  reg_sel;
    logic        unused_adr;

    assign unused_adr = ^{bus.t_adr[31:4], bus.t_adr[1:0]};

    // The registered ack masks the next cycle, giving one access per two cycles.
    assign req        = bus.t_cyc && bus.t_stb && !ack_q;
    assign wr         = req && bus.t_we;
    assign reg_sel    = bus.t_adr[3:2];
    assign wr_ctrl    = wr && (reg_sel == REG_CTRL);
    assign wr_status  = wr && (reg_sel == REG_STATUS);
    assign wr_count   = wr && (reg_sel == REG_COUNT);
    assign wr_compare = wr && (reg_sel == REG_COMPARE);

`ifdef FWVEXRISC_WB_TIMER_PRESCALE_EN
    // Touching the prescale byte restarts the divider so the new ratio starts clean.
    fwvexrisc_timer_prescaler u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .en       (ctrl_q.en),
        .prescale (ctrl_q.prescale),
        .clear    (wr_ctrl && bus.t_sel[1]),
        .tick     (tick)
    );
`else
    assign tick = ctrl_q.en;
`endif

    assign match = tick && (count_q == compare_q);
    assign irq   = pending_q && ctrl_q.irq_en;

    always_comb begin
        ctrl_d    = ctrl_q;
        pending_d = pending_q;
        count_d   = count_q;
        compare_d = compare_q;
        dat_r_d   = dat_r_q;

        if (wr_ctrl)
            ctrl_d = ctrl_t'(byte_merge(32'(ctrl_q), bus.t_dat_w, bus.t_sel) & CTRL_MASK);
        if (wr_compare)
            compare_d = byte_merge(compare_q, bus.t_dat_w, bus.t_sel);

        if (tick)
            count_d = (match && ctrl_q.auto_reload) ? 32'd0 : count_q + 32'd1;
        // Bus write beats a same-cycle increment.
        if (wr_count)
            count_d = byte_merge(count_q, bus.t_dat_w, bus.t_sel);

        // A same-cycle match beats the write-1-to-clear.
        if (wr_status && bus.t_sel[0] && bus.t_dat_w[0])
            pending_d = 1'b0;
        if (match)
            pending_d = 1'b1;

        // Read data captures pre-update register values.
        if (req) begin
            case (reg_sel)
                REG_CTRL:   dat_r_d = 32'(ctrl_q);
                REG_STATUS: dat_r_d = {31'd0, pending_q};
                REG_COUNT:  dat_r_d = count_q;
                default:    dat_r_d = compare_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            pending_q <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= RESET_COMPARE;
            ack_q     <= 1'b0;
            dat_r_q   <= 32'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ack_q     <= req;
            dat_r_q   <= dat_r_d;
        end
    end

    assign bus.t_ack   = ack_q;
    assign bus.t_dat_r = dat_r_q;
endmodule

// File: tb/tb_fwvexrisc_wb_timer.sv
// tb/tb_fwvexrisc_wb_timer.sv - scoreboard testbench for fwvexrisc_wb_timer
module tb_fwvexrisc_wb_timer;
    import fwvexrisc_wb_timer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic irq;

    fwvexrisc_wb_timer_if bus ();

    fwvexrisc_wb_timer #(.RESET_COMPARE(32'hFFFF_FFFF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack pops one scoreboard entry; reads compare data.
    always @(negedge clock) begin
        if (reset && bus.t_ack) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (bus.t_dat_r !== e.exp) begin
                        n_fail++;
                        $display("FAIL read_data: got %h expected %h at %0t", bus.t_dat_r, e.exp, $time);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge following the ack.
    task automatic bus_op(input logic we, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] sel, input logic [31:0] exp);
        sb_t e;
        e.chk = !we;
        e.exp = exp;
        sb.push_back(e);
        bus.t_adr   = {28'd0, a, 2'b00};
        bus.t_dat_w = d;
        bus.t_sel   = sel;
        bus.t_we    = we;
        bus.t_cyc   = 1'b1;
        bus.t_stb   = 1'b1;
        @(posedge clock); #1;
        bus.t_cyc = 1'b0;
        bus.t_stb = 1'b0;
        bus.t_we  = 1'b0;
        check("ack_latency", {31'd0, bus.t_ack}, 32'd1);
        @(posedge clock); #1;
        check("ack_width", {31'd0, bus.t_ack}, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_op(1'b1, a, d, 4'hF, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        bus_op(1'b0, a, 32'd0, 4'hF, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.t_adr = '0; bus.t_dat_w = '0; bus.t_sel = '0;
        bus.t_we = 1'b0; bus.t_cyc = 1'b0; bus.t_stb = 1'b0;

        // Reset
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        check("reset_ack", {31'd0, bus.t_ack}, 32'd0);
        check("reset_dat_r", bus.t_dat_r, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rd(REG_CTRL, 32'd0);
        rd(REG_STATUS, 32'd0);
        rd(REG_COUNT, 32'd0);
        rd(REG_COMPARE, 32'hFFFF_FFFF);

        // Byte lanes and empty select
        bus_op(1'b1, REG_COMPARE, 32'hAABB_CCDD, 4'b0101, 32'd0);
        rd(REG_COMPARE, 32'hFFBB_FFDD);
        bus_op(1'b1, REG_COMPARE, 32'h0000_0000, 4'b0000, 32'd0);
        rd(REG_COMPARE, 32'hFFBB_FFDD);

        // Unimplemented CTRL bits read 0
        wr(REG_CTRL, 32'hFFFF_FFF8);
`ifdef FWVEXRISC_WB_TIMER_PRESCALE_EN
        rd(REG_CTRL, 32'h0000_FF00);
`else
        rd(REG_CTRL, 32'h0000_0000);
`endif
        wr(REG_CTRL, 32'd0);

        // Match with auto-reload; enable lands at edge E
        wr(REG_COMPARE, 32'd5);
        wr(REG_CTRL, 32'h7);
        cycles(4);
        check("irq_before_match", {31'd0, irq}, 32'd0);
        cycles(1);
        check("irq_at_match", {31'd0, irq}, 32'd1);
        // Reads spaced 7 cycles apart step through 0..5 of the 6-cycle period.
        for (int i = 0; i < 6; i++) begin
            rd(REG_COUNT, 32'(i));
            cycles(5);
        end
        wr(REG_STATUS, 32'd1);
        check("irq_after_clear", {31'd0, irq}, 32'd0);
        cycles(3);
        wr(REG_STATUS, 32'd1);          // lands on a match edge
        check("irq_clear_vs_match", {31'd0, irq}, 32'd1);
        rd(REG_STATUS, 32'd1);
        wr(REG_CTRL, 32'd0);
        rd(REG_COUNT, 32'd4);
        wr(REG_STATUS, 32'd1);
        rd(REG_STATUS, 32'd0);

        // COUNT write on a tick edge: write wins, then two more ticks
        wr(REG_COMPARE, 32'hFFFF_FFFF);
        wr(REG_CTRL, 32'h1);
        wr(REG_COUNT, 32'd100);
        wr(REG_CTRL, 32'h0);
        rd(REG_COUNT, 32'd102);

        // Wrap without match
        wr(REG_COUNT, 32'hFFFF_FFFF);
        wr(REG_COMPARE, 32'd7);
        wr(REG_CTRL, 32'h1);
        wr(REG_CTRL, 32'h0);
        rd(REG_COUNT, 32'd1);
        rd(REG_STATUS, 32'd0);

        // Match without auto-reload continues counting
        wr(REG_COUNT, 32'd6);
        wr(REG_CTRL, 32'h1);
        wr(REG_CTRL, 32'h0);
        rd(REG_COUNT, 32'd8);
        rd(REG_STATUS, 32'd1);
        check("irq_masked", {31'd0, irq}, 32'd0);

`ifdef FWVEXRISC_WB_TIMER_PRESCALE_EN
        // Divide by 4 for 40 cycles
        wr(REG_COUNT, 32'd0);
        wr(REG_COMPARE, 32'hFFFF_FFFF);
        wr(REG_CTRL, 32'h0000_0301);
        cycles(38);
        wr(REG_CTRL, 32'h0);
        rd(REG_COUNT, 32'd10);
        rd(REG_CTRL, 32'h0);
`endif

        wr(REG_CTRL, 32'h2);
        check("irq_enabled", {31'd0, irq}, 32'd1);

        // Reset during an access
        bus.t_adr = {28'd0, REG_COUNT, 2'b00};
        bus.t_we  = 1'b0;
        bus.t_sel = 4'hF;
        bus.t_cyc = 1'b1;
        bus.t_stb = 1'b1;
        #3 reset = 1'b0;
        #1 check("rst_mid_ack_now", {31'd0, bus.t_ack}, 32'd0);
        @(posedge clock); #1;
        check("rst_mid_ack_edge", {31'd0, bus.t_ack}, 32'd0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        check("rst_mid_dat_r", bus.t_dat_r, 32'd0);
        bus.t_cyc = 1'b0;
        bus.t_stb = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        rd(REG_CTRL, 32'd0);
        rd(REG_STATUS, 32'd0);
        rd(REG_COUNT, 32'd0);
        rd(REG_COMPARE, 32'hFFFF_FFFF);

        cycles(2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
